// File: rtl/byteswap_axi_mem_responder.sv
// AXI4 burst slave (reduced signal set) backed by an on-chip word array.
// Optional build macro BYTESWAP_AXI_MEM_STALL_EN: LFSR-driven stalls on awready/wready/arready.
module byteswap_axi_mem_responder #(
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 64,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 512,
    parameter int unsigned C_MEM_DEPTH_WORDS  = 1024
) (
    input  logic                              ap_clk,
    input  logic                              ap_rst_n,
    input  logic                              s_axi_awvalid,
    output logic                              s_axi_awready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [7:0]                        s_axi_awlen,
    input  logic                              s_axi_wvalid,
    output logic                              s_axi_wready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                              s_axi_wlast,
    output logic                              s_axi_bvalid,
    input  logic                              s_axi_bready,
    input  logic                              s_axi_arvalid,
    output logic                              s_axi_arready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [7:0]                        s_axi_arlen,
    output logic                              s_axi_rvalid,
    input  logic                              s_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic                              s_axi_rlast,
    output logic                              err_wlast
);

    localparam int unsigned STRB_W = C_S_AXI_DATA_WIDTH / 8;
    localparam int unsigned OFS    = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(C_MEM_DEPTH_WORDS);

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_DATA  = 2'd1;
    localparam logic [1:0] W_RESP  = 2'd2;
    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_FETCH = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;

    logic [1:0]                    r_wstate;
    logic [1:0]                    w_wstate_nxt;
    logic [1:0]                    r_rstate;
    logic [1:0]                    w_rstate_nxt;
    logic [IDX_W-1:0]              r_widx;
    logic [7:0]                    r_wlen;
    logic [7:0]                    r_wbeat;
    logic [IDX_W-1:0]              r_ridx;
    logic [7:0]                    r_rlen;
    logic [7:0]                    r_rbeat;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
    logic                          r_err_wlast;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_mem [C_MEM_DEPTH_WORDS];

    logic w_stall_aw, w_stall_w, w_stall_ar;
    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic w_wlast_beat, w_rlast_beat, w_mem_we;
    logic w_unused;

`ifdef BYTESWAP_AXI_MEM_STALL_EN
    logic [15:0] r_lfsr;

    // Fibonacci LFSR, taps 16/14/13/11
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) r_lfsr <= 16'hACE1;
        else           r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end

    assign w_stall_aw = r_lfsr[0];
    assign w_stall_w  = r_lfsr[5];
    assign w_stall_ar = r_lfsr[11];
`else
    assign w_stall_aw = 1'b0;
    assign w_stall_w  = 1'b0;
    assign w_stall_ar = 1'b0;
`endif

    // Handshake outputs decode registered state only
    assign s_axi_awready = (r_wstate == W_IDLE) && !w_stall_aw;
    assign s_axi_wready  = (r_wstate == W_DATA) && !w_stall_w;
    assign s_axi_bvalid  = (r_wstate == W_RESP);
    assign s_axi_arready = (r_rstate == R_IDLE) && !w_stall_ar;
    assign s_axi_rvalid  = (r_rstate == R_DATA);
    assign s_axi_rlast   = (r_rstate == R_DATA) && w_rlast_beat;
    assign s_axi_rdata   = r_rdata;
    assign err_wlast     = r_err_wlast;

    assign w_aw_hs      = s_axi_awvalid & s_axi_awready;
    assign w_w_hs       = s_axi_wvalid  & s_axi_wready;
    assign w_b_hs       = s_axi_bvalid  & s_axi_bready;
    assign w_ar_hs      = s_axi_arvalid & s_axi_arready;
    assign w_r_hs       = s_axi_rvalid  & s_axi_rready;
    assign w_wlast_beat = (r_wbeat == r_wlen);
    assign w_rlast_beat = (r_rbeat == r_rlen);
    assign w_mem_we     = w_w_hs & ap_rst_n;
    assign w_unused     = ^{s_axi_awaddr, s_axi_araddr};

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
            W_DATA:  if (w_w_hs && w_wlast_beat) w_wstate_nxt = W_RESP;
            W_RESP:  if (w_b_hs) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_FETCH;
            R_FETCH: w_rstate_nxt = R_DATA;
            R_DATA:  if (w_r_hs) w_rstate_nxt = w_rlast_beat ? R_IDLE : R_FETCH;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Write burst bookkeeping; the burst ends on the counter, wlast only flags errors
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_widx      <= '0;
            r_wlen      <= '0;
            r_wbeat     <= '0;
            r_err_wlast <= 1'b0;
        end else if (w_aw_hs) begin
            r_widx  <= s_axi_awaddr[OFS +: IDX_W];
            r_wlen  <= s_axi_awlen;
            r_wbeat <= '0;
        end else if (w_w_hs) begin
            r_widx  <= r_widx + IDX_W'(1);
            r_wbeat <= r_wbeat + 8'd1;
            if (s_axi_wlast != w_wlast_beat) r_err_wlast <= 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) r_mem[r_widx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    // Read burst bookkeeping; the fetch sees pre-write data on a same-word collision
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_ridx  <= '0;
            r_rlen  <= '0;
            r_rbeat <= '0;
            r_rdata <= '0;
        end else begin
            if (w_ar_hs) begin
                r_ridx  <= s_axi_araddr[OFS +: IDX_W];
                r_rlen  <= s_axi_arlen;
                r_rbeat <= '0;
            end else if (w_r_hs && !w_rlast_beat) begin
                r_ridx  <= r_ridx + IDX_W'(1);
                r_rbeat <= r_rbeat + 8'd1;
            end
            if (r_rstate == R_FETCH) r_rdata <= r_mem[r_ridx];
        end
    end

endmodule

// File: tb/tb_byteswap_axi_mem_responder.sv
// Self-checking bench for byteswap_axi_mem_responder: random bursts against an array model.
module tb_byteswap_axi_mem_responder;

    localparam int unsigned AW    = 64;
    localparam int unsigned DW    = 512;
    localparam int unsigned SW    = DW / 8;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned OFS   = 6;
    localparam int unsigned IDX_W = 10;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          awvalid = 1'b0, awready;
    logic [AW-1:0] awaddr = '0;
    logic [7:0]    awlen = '0;
    logic          wvalid = 1'b0, wready;
    logic [DW-1:0] wdata = '0;
    logic [SW-1:0] wstrb = '0;
    logic          wlast = 1'b0;
    logic          bvalid, bready = 1'b0;
    logic          arvalid = 1'b0, arready;
    logic [AW-1:0] araddr = '0;
    logic [7:0]    arlen = '0;
    logic          rvalid, rready = 1'b0;
    logic [DW-1:0] rdata;
    logic          rlast;
    logic          err_wlast;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem_model [DEPTH];
    logic          err_model;
    logic [DW-1:0] wd [256];
    logic [SW-1:0] ws [256];
    logic [DW-1:0] last_rdata;

    byteswap_axi_mem_responder #(
        .C_S_AXI_ADDR_WIDTH(AW),
        .C_S_AXI_DATA_WIDTH(DW),
        .C_MEM_DEPTH_WORDS (DEPTH)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_wlast(wlast), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rlast(rlast),
        .err_wlast(err_wlast)
    );

    always #5 ap_clk = ~ap_clk;

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Byte address of word idx with random junk in the ignored bits
    function automatic logic [AW-1:0] junk_addr(input int idx);
        logic [AW-1:0] a;
        a = {$urandom, $urandom};
        a[OFS +: IDX_W] = IDX_W'(idx);
        return a;
    endfunction

    task automatic axi_write(input logic [AW-1:0] addr, input int len, input int bad_last, input int hold_b);
        int base;
        int cyc;
        int idx;
        logic wl;
        base = int'(addr[OFS +: IDX_W]);
        awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
        cyc = 0;
        while (awready !== 1'b1 && cyc < 100) begin @(posedge ap_clk); #1; cyc++; end
        if (cyc >= 100) begin
            checks++; errors++; $display("FAIL aw_timeout awready stuck at %b", awready);
            awvalid = 1'b0; return;
        end
        @(posedge ap_clk); #1; awvalid = 1'b0;
        checks++;
        if (wready !== 1'b1) begin errors++; $display("FAIL wready_latency got %b exp 1", wready); end
        for (int b = 0; b <= len; b++) begin
            wl = (bad_last >= 0) ? (b == bad_last) : (b == len);
            wvalid = 1'b1; wdata = wd[b]; wstrb = ws[b]; wlast = wl;
            cyc = 0;
            while (wready !== 1'b1 && cyc < 100) begin @(posedge ap_clk); #1; cyc++; end
            if (cyc >= 100) begin
                checks++; errors++; $display("FAIL w_timeout beat %0d", b);
                wvalid = 1'b0; return;
            end
            @(posedge ap_clk); #1;
            idx = (base + b) % DEPTH;
            for (int k = 0; k < SW; k++) if (ws[b][k]) mem_model[idx][k*8 +: 8] = wd[b][k*8 +: 8];
            if (wl != (b == len)) err_model = 1'b1;
            checks++;
            if (err_wlast !== err_model) begin
                errors++; $display("FAIL err_wlast beat %0d got %b exp %b", b, err_wlast, err_model);
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        checks++;
        if (bvalid !== 1'b1) begin errors++; $display("FAIL bvalid_latency got %b exp 1", bvalid); end
        repeat (hold_b) begin
            @(posedge ap_clk); #1;
            checks++;
            if (bvalid !== 1'b1 || awready !== 1'b0) begin
                errors++; $display("FAIL b_hold bvalid %b awready %b exp 1 0", bvalid, awready);
            end
        end
        bready = 1'b1;
        @(posedge ap_clk); #1; bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1) begin
            errors++; $display("FAIL b_done bvalid %b awready %b exp 0 1", bvalid, awready);
        end
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input int len, input int hold_r, input int rst_beat);
        int base;
        int cyc;
        logic [DW-1:0] exp;
        logic [DW-1:0] held;
        base = int'(addr[OFS +: IDX_W]);
        araddr = addr; arlen = 8'(len); arvalid = 1'b1;
        cyc = 0;
        while (arready !== 1'b1 && cyc < 100) begin @(posedge ap_clk); #1; cyc++; end
        if (cyc >= 100) begin
            checks++; errors++; $display("FAIL ar_timeout arready stuck at %b", arready);
            arvalid = 1'b0; return;
        end
        @(posedge ap_clk); #1; arvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            checks++;
            if (rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_gap beat %0d got %b exp 0", b, rvalid); end
            @(posedge ap_clk); #1;
            exp = mem_model[(base + b) % DEPTH];
            checks++;
            if (rvalid !== 1'b1) begin errors++; $display("FAIL rvalid_latency beat %0d got %b exp 1", b, rvalid); end
            checks++;
            if (rdata !== exp) begin errors++; $display("FAIL rdata beat %0d got %h exp %h", b, rdata, exp); end
            checks++;
            if (rlast !== (b == len)) begin
                errors++; $display("FAIL rlast beat %0d got %b exp %b", b, rlast, (b == len));
            end
            last_rdata = rdata;
            if (b == rst_beat) begin
                ap_rst_n = 1'b0;
                @(posedge ap_clk); #1;
                err_model = 1'b0;
                checks++;
                if (rvalid !== 1'b0 || rlast !== 1'b0 || rdata !== '0 || err_wlast !== 1'b0) begin
                    errors++; $display("FAIL rst_mid_read rvalid %b rlast %b err %b exp 0 0 0", rvalid, rlast, err_wlast);
                end
                ap_rst_n = 1'b1;
                @(posedge ap_clk); #1;
                checks++;
                if (arready !== 1'b1 || rvalid !== 1'b0) begin
                    errors++; $display("FAIL rst_release arready %b rvalid %b exp 1 0", arready, rvalid);
                end
                return;
            end
            if (b == 0 && hold_r > 0) begin
                held = rdata;
                repeat (hold_r) begin
                    @(posedge ap_clk); #1;
                    checks++;
                    if (rvalid !== 1'b1 || rdata !== held) begin
                        errors++; $display("FAIL r_hold rvalid %b rdata %h exp %h", rvalid, rdata, held);
                    end
                end
            end
            rready = 1'b1;
            @(posedge ap_clk); #1; rready = 1'b0;
        end
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            errors++; $display("FAIL r_done rvalid %b arready %b exp 0 1", rvalid, arready);
        end
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        err_model = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        checks++;
        if (bvalid !== 1'b0 || rvalid !== 1'b0 || rlast !== 1'b0 || rdata !== '0 || err_wlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs bvalid %b rvalid %b rlast %b err %b rdata %h exp all 0",
                     bvalid, rvalid, rlast, err_wlast, rdata);
        end
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        checks++;
        if (awready !== 1'b1 || arready !== 1'b1 || wready !== 1'b0) begin
            errors++; $display("FAIL reset_readies aw %b ar %b w %b exp 1 1 0", awready, arready, wready);
        end
    endtask

    // Fills the whole array with 256-beat bursts, then reads one 256-beat burst back
    task automatic test_fill();
        for (int blk = 0; blk < 4; blk++) begin
            for (int b = 0; b < 256; b++) begin wd[b] = rand_word(); ws[b] = '1; end
            axi_write(junk_addr(blk * 256), 255, -1, 0);
        end
        axi_read(junk_addr(0), 255, 0, -1);
    endtask

    task automatic test_basic();
        for (int b = 0; b < 4; b++) begin wd[b] = {16{32'(b)}}; ws[b] = '1; end
        axi_write(64'h0, 3, -1, 0);
        axi_read(64'h0, 3, 0, -1);
    endtask

    task automatic test_partial_strobe();
        logic [DW-1:0] exp;
        wd[0] = '1; ws[0] = '1;
        axi_write(64'd5 * 64, 0, -1, 0);
        wd[0] = '0; ws[0] = 64'h1;
        axi_write(64'd5 * 64, 0, -1, 0);
        axi_read(64'd5 * 64, 0, 0, -1);
        exp = '1;
        exp[7:0] = 8'h00;
        checks++;
        if (last_rdata !== exp) begin errors++; $display("FAIL partial_strobe got %h exp %h", last_rdata, exp); end
    endtask

    task automatic test_wrap();
        for (int b = 0; b < 2; b++) begin wd[b] = rand_word(); ws[b] = '1; end
        axi_write(junk_addr(DEPTH - 1), 1, -1, 0);
        axi_read(junk_addr(0), 0, 0, -1);
        checks++;
        if (last_rdata !== wd[1]) begin errors++; $display("FAIL wrap_word0 got %h exp %h", last_rdata, wd[1]); end
        axi_read(junk_addr(DEPTH - 1), 1, 0, -1);
    endtask

    task automatic test_bad_wlast();
        int base;
        base = int'($urandom_range(0, DEPTH - 1));
        for (int b = 0; b < 3; b++) begin wd[b] = rand_word(); ws[b] = '1; end
        axi_write(junk_addr(base), 2, 1, 0);
        axi_read(junk_addr(base), 2, 0, -1);
    endtask

    task automatic test_backpressure();
        int base;
        base = int'($urandom_range(0, DEPTH - 1));
        for (int b = 0; b < 2; b++) begin wd[b] = rand_word(); ws[b] = SW'({$urandom, $urandom}); end
        axi_write(junk_addr(base), 1, -1, 10);
        axi_read(junk_addr(base), 1, 5, -1);
    endtask

    task automatic test_reset_mid_read();
        int base;
        base = int'($urandom_range(0, DEPTH - 1));
        for (int b = 0; b < 8; b++) begin wd[b] = rand_word(); ws[b] = '1; end
        axi_write(junk_addr(base), 7, -1, 0);
        axi_read(junk_addr(base), 7, 0, 2);
        axi_read(junk_addr(base), 7, 0, -1);
    endtask

    task automatic test_back_to_back();
        int base;
        int len;
        for (int n = 0; n < 12; n++) begin
            base = int'($urandom_range(0, DEPTH - 1));
            len  = int'($urandom_range(0, 15));
            for (int b = 0; b <= len; b++) begin wd[b] = rand_word(); ws[b] = SW'({$urandom, $urandom}); end
            axi_write(junk_addr(base), len, -1, int'($urandom_range(0, 2)));
            axi_read(junk_addr(base), len, int'($urandom_range(0, 2)), -1);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_basic();
        test_partial_strobe();
        test_wrap();
        test_bad_wlast();
        test_backpressure();
        test_reset_mid_read();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
